glitch_clk_gen: RTL and testbench
=================================

// Module: glitch_clk_gen
// PURPOSE
// - Generates the target clock for a device under test from the fast system clock.
// - Can inject one shortened high phase (clock glitch) at a programmed target-cycle offset after arm.
// - Sits directly upstream of the target: its target_clk drives the target's clock input.
// - The target flags a glitch when a high phase is below 0.8x its first measured half period.
// PARAMETERS
// - HALF_W  default 8   width of half_period / glitch_width fields (clk cycles)
// - CNT_W   default 16  width of delay and target edge counter
// PORTS
// - clk           in   1       system clock; every register lives in this one clock domain
// - rst           in   1       synchronous, active-high reset
// - half_period   in   HALF_W  clk cycles per target half period (normal high and low phase)
// - glitch_width  in   HALF_W  clk cycles of the glitched high phase
// - delay         in   CNT_W   glitch lands on target rising edge number delay+1 after arm
// - arm           in   1       1-cycle request to start a glitch attempt
// - abort         in   1       cancel a pending attempt
// - target_clk    out  1       registered target clock
// - target_rise   out  1       1-cycle pulse in the clk cycle target_clk becomes 1
// - busy          out  1       attempt pending (WAIT or GLITCH)
// - glitch_active out  1       high for exactly the glitched high phase (scope trigger)
// - done          out  1       1-cycle pulse when the glitched high phase ends
// BEHAVIOUR
// - Reset values: target_clk=0, target_rise=0, busy=0, glitch_active=0, done=0. Internal phase_cnt=0, edge_cnt=0, state=IDLE.
// - Clock generation: phase_cnt counts clk cycles within the current phase. At terminal count:
//   - target_clk toggles and phase_cnt returns to 0.
//   - Normal terminal count is hp-1, with hp=max(half_period,2).
//   - The target clock runs continuously in every state, including IDLE.
// - half_period is sampled at each phase boundary, so a change never truncates a phase already in progress.
// - Glitch width: gw = clamp(glitch_width, 1, hp-1), captured at arm together with delay.
// - States:
//   - IDLE: arm -> WAIT. busy goes to 1 on the next cycle; edge_cnt=0.
//   - WAIT: count each target rising edge.
//     - On the rising edge where edge_cnt==delay, go to GLITCH. glitch_active=1 on the same cycle target_clk=1.
//     - Otherwise increment edge_cnt.
//   - GLITCH: the high phase terminal count is gw-1, giving a high phase of exactly gw clk cycles.
//     - At that falling edge: glitch_active=0, done=1 for one cycle, busy=0, state -> IDLE.
//     - The following low phase is a normal hp.
// - arm while busy: ignored, no restart.
// - abort in WAIT: -> IDLE, busy=0, done not pulsed.
// - abort in GLITCH: ignored; a glitch already on the wire completes, so the waveform never shows a runt pulse.
// - arm and abort in the same IDLE cycle: abort wins and the block stays IDLE.
// - If the arm cycle coincides with a rising edge, that edge is not counted; counting starts with the next rising edge.
// - edge_cnt saturates at its maximum value; delay = 2^CNT_W-1 is legal.
// - rst mid-attempt: all outputs return to their reset values on the next clk edge; an in-progress glitch is cut.
// TESTING
// 1. hp=10, no arm -> target_clk has period 20 clk, 50% duty; target_rise once per 20 cycles; busy/done stay 0.
// 2. hp=10, gw=5, delay=3, arm -> 4th rising edge after arm has a high phase of 5 clk; glitch_active is high for 5 cycles; done pulses at that falling edge; the next low phase is 10.
// 3. hp=10, gw=0 / gw=12 -> glitched high phase is 1 / 9 clk respectively.
// 4. hp=10, delay=40, abort at edge 20 -> no shortened phase, no done, busy=0 one cycle after abort; re-arm with delay=0 glitches the first edge after arm.
// 5. arm held for 3 cycles and re-pulsed during WAIT -> exactly one glitch per attempt; change half_period 10->6 mid-phase -> the current phase finishes at 10 and the next phase is 6.
// 6. rst asserted during GLITCH -> next cycle target_clk=0, glitch_active=0, busy=0, done=0; clock restarts with a full low phase.

Source files
------------

// File: rtl/glitch_clk_gen_if.sv
// Control/status bundle between a glitch-attack controller (master) and the
// glitch clock generator (slave).
interface glitch_clk_gen_if #(
  parameter int unsigned HALF_W = 8,
  parameter int unsigned CNT_W  = 16
);
  logic [HALF_W-1:0] half_period;
  logic [HALF_W-1:0] glitch_width;
  logic [CNT_W-1:0]  delay;
  logic              arm;
  logic              abort;
  logic              target_clk;
  logic              target_rise;
  logic              busy;
  logic              glitch_active;
  logic              done;

  modport master (
    output half_period, glitch_width, delay, arm, abort,
    input  target_clk, target_rise, busy, glitch_active, done
  );

  modport slave (
    input  half_period, glitch_width, delay, arm, abort,
    output target_clk, target_rise, busy, glitch_active, done
  );
endinterface

// File: rtl/glitch_clk_gen.sv
// Target clock generator that can replace one high phase with a shortened
// glitch phase, landing on a programmed target rising edge after arm.
module glitch_clk_gen #(
  parameter int unsigned HALF_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input logic             clk,
  input logic             rst,
  glitch_clk_gen_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StGlitch
  } state_e;

  localparam logic [HALF_W-1:0] HpMin   = HALF_W'(2);
  localparam logic [HALF_W-1:0] HalfOne = HALF_W'(1);
  localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);

  state_e            state;
  logic [HALF_W-1:0] phase_cnt;
  logic [HALF_W-1:0] hp_cur;
  logic [HALF_W-1:0] gw_cap;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  delay_cap;

  logic [HALF_W-1:0] hp_in;
  logic [HALF_W-1:0] gw_in;
  logic [HALF_W-1:0] term_cnt;
  logic              at_term;
  logic              rise_now;

  always_comb begin
    hp_in = (bus.half_period < HpMin) ? HpMin : bus.half_period;

    // Glitch width is clamped against the half period in force at arm time.
    gw_in = bus.glitch_width;
    if (bus.glitch_width == '0) begin
      gw_in = HalfOne;
    end else if (bus.glitch_width > (hp_cur - HalfOne)) begin
      gw_in = hp_cur - HalfOne;
    end

    term_cnt = hp_cur - HalfOne;
    if ((state == StGlitch) && bus.target_clk) begin
      term_cnt = gw_cap - HalfOne;
    end

    at_term  = (phase_cnt >= term_cnt);
    rise_now = at_term && !bus.target_clk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= StIdle;
      phase_cnt         <= '0;
      hp_cur            <= hp_in;
      gw_cap            <= HalfOne;
      edge_cnt          <= '0;
      delay_cap         <= '0;
      bus.target_clk    <= 1'b0;
      bus.target_rise   <= 1'b0;
      bus.busy          <= 1'b0;
      bus.glitch_active <= 1'b0;
      bus.done          <= 1'b0;
    end else begin
      bus.target_rise <= rise_now;
      bus.done        <= 1'b0;

      // The clock free-runs in every state; half_period is only taken at a phase boundary.
      if (at_term) begin
        bus.target_clk <= ~bus.target_clk;
        phase_cnt      <= '0;
        hp_cur         <= hp_in;
      end else begin
        phase_cnt <= phase_cnt + HalfOne;
      end

      case (state)
        StIdle: begin
          if (bus.arm && !bus.abort) begin
            state     <= StWait;
            bus.busy  <= 1'b1;
            edge_cnt  <= '0;
            delay_cap <= bus.delay;
            gw_cap    <= gw_in;
          end
        end

        StWait: begin
          if (bus.abort) begin
            state    <= StIdle;
            bus.busy <= 1'b0;
          end else if (rise_now) begin
            if (edge_cnt == delay_cap) begin
              state             <= StGlitch;
              bus.glitch_active <= 1'b1;
            end else if (edge_cnt != '1) begin
              edge_cnt <= edge_cnt + CntOne;
            end
          end
        end

        StGlitch: begin
          // Abort is deliberately ignored here so the shortened pulse is never cut.
          if (at_term) begin
            state             <= StIdle;
            bus.glitch_active <= 1'b0;
            bus.done          <= 1'b1;
            bus.busy          <= 1'b0;
          end
        end

        default: begin
          state             <= StIdle;
          bus.busy          <= 1'b0;
          bus.glitch_active <= 1'b0;
        end
      endcase
    end
  end

  a_glitch_implies_busy : assert property (@(posedge clk) disable iff (rst)
    bus.glitch_active |-> bus.busy);
  a_done_not_busy : assert property (@(posedge clk) disable iff (rst)
    bus.done |-> !bus.busy);
  a_rise_is_high : assert property (@(posedge clk) disable iff (rst)
    bus.target_rise |-> bus.target_clk);

endmodule

// File: tb/tb_glitch_clk_gen.sv
// Self-checking bench for glitch_clk_gen: phase-length reference model plus
// directed waveform measurements and randomized traffic.
module tb_glitch_clk_gen;
  localparam int unsigned HALF_W = 8;
  localparam int unsigned CNT_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  glitch_clk_gen_if #(.HALF_W(HALF_W), .CNT_W(CNT_W)) bus ();

  glitch_clk_gen #(.HALF_W(HALF_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  // Reference model: current phase length and position, attempt as a rise countdown.
  bit m_level, m_rise, m_busy, m_ga, m_done;
  int m_pos, m_len, m_hp, m_gw, m_togo, m_mode;

  // Waveform measurements taken from the DUT pins.
  logic prev_tclk;
  int run = 0, hi_last = 0, lo_last = 0, ga_run = 0, ga_last = 0;
  int done_total = 0, rise_total = 0;

  function automatic void model_step();
    bit boundary, enter_glitch;
    int hp_in, g;
    hp_in = (int'(bus.half_period) < 2) ? 2 : int'(bus.half_period);
    if (rst) begin
      m_level = 0; m_pos = 0; m_hp = hp_in; m_len = hp_in;
      m_rise = 0; m_busy = 0; m_ga = 0; m_done = 0; m_mode = 0; m_togo = 0;
      return;
    end
    boundary = (m_pos == m_len - 1);
    enter_glitch = 0;
    m_rise = 0;
    m_done = 0;
    if (m_mode == 0) begin
      if (bus.arm && !bus.abort) begin
        m_mode = 1; m_busy = 1; m_togo = int'(bus.delay) + 1;
        g = int'(bus.glitch_width);
        if (g < 1) g = 1;
        if (g > m_hp - 1) g = m_hp - 1;
        m_gw = g;
      end
    end else if (m_mode == 1) begin
      if (bus.abort) begin
        m_mode = 0; m_busy = 0;
      end else if (boundary && !m_level) begin
        m_togo--;
        if (m_togo == 0) begin
          m_mode = 2; m_ga = 1; enter_glitch = 1;
        end
      end
    end else begin
      if (boundary) begin
        m_mode = 0; m_ga = 0; m_done = 1; m_busy = 0;
      end
    end
    if (boundary) begin
      m_level = !m_level;
      m_pos = 0;
      m_hp = hp_in;
      m_len = enter_glitch ? m_gw : hp_in;
      m_rise = m_level;
    end else begin
      m_pos++;
    end
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      total++;
      if ({bus.target_clk, bus.target_rise, bus.busy, bus.glitch_active, bus.done} !==
          {m_level, m_rise, m_busy, m_ga, m_done}) begin
        bad++;
        $display("FAIL cycle_model t=%0t dut(clk,rise,busy,ga,done)=%b%b%b%b%b model=%b%b%b%b%b",
                 $time, bus.target_clk, bus.target_rise, bus.busy, bus.glitch_active, bus.done,
                 m_level, m_rise, m_busy, m_ga, m_done);
      end
    end
    if (bus.target_clk === prev_tclk) begin
      run++;
    end else begin
      if (prev_tclk === 1'b1) hi_last = run;
      else lo_last = run;
      run = 1;
    end
    prev_tclk = bus.target_clk;
    if (bus.glitch_active === 1'b1) ga_run++;
    else if (ga_run != 0) begin
      ga_last = ga_run;
      ga_run = 0;
    end
    if (bus.done === 1'b1) done_total++;
    if (bus.target_rise === 1'b1) rise_total++;
    model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_rise(input int bound);
    bit ok;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (bus.target_rise === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL wait_rise timeout actual=none required=rise within %0d", bound);
    end
  endtask

  task automatic wait_done(input int bound);
    bit ok;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL wait_done timeout actual=none required=done within %0d", bound);
    end
  endtask

  // Puts the next arm in mid-high-phase so it never coincides with a rising edge.
  task automatic align();
    wait_rise(40);
    tick();
    tick();
  endtask

  task automatic pulse_arm(input int gw, input int dl);
    bus.glitch_width = HALF_W'(gw);
    bus.delay = CNT_W'(dl);
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic glitch_shot(input string name, input int gw, input int dl, input int exp_w);
    int r0, d0;
    align();
    r0 = rise_total;
    d0 = done_total;
    pulse_arm(gw, dl);
    wait_done(40 * (dl + 2));
    tick();
    check({name, "_high_len"}, hi_last, exp_w);
    check({name, "_ga_len"}, ga_last, exp_w);
    check({name, "_rises"}, rise_total - r0, dl + 1);
    check({name, "_done_cnt"}, done_total - d0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bus.half_period = 8'd10;
    bus.glitch_width = '0;
    bus.delay = '0;
    bus.arm = 1'b0;
    bus.abort = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check_en = 1'b1;
    check("rst_outputs", {bus.target_clk, bus.target_rise, bus.busy, bus.glitch_active,
                          bus.done}, 0);
    rst = 1'b0;

    // Free-running clock, nothing armed.
    wait_rise(40);
    wait_rise(40);
    tick();
    check("idle_high_len", hi_last, 10);
    check("idle_low_len", lo_last, 10);
    check("idle_done_cnt", done_total, 0);

    // Basic glitch, then the following low phase.
    glitch_shot("g5_d3", 5, 3, 5);
    wait_rise(40);
    tick();
    check("post_glitch_low", lo_last, 10);

    glitch_shot("gw0", 0, 0, 1);
    glitch_shot("gw12", 12, 0, 9);

    // Abort mid-wait, then an immediate re-arm.
    align();
    d0 = done_total;
    pulse_arm(5, 40);
    for (int i = 0; i < 20; i++) wait_rise(40);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    repeat (60) tick();
    check("abort_no_done", done_total - d0, 0);
    glitch_shot("rearm_d0", 3, 0, 3);

    // Held arm and a re-pulse during wait give one glitch.
    align();
    d0 = done_total;
    bus.glitch_width = 8'd4;
    bus.delay = 16'd5;
    bus.arm = 1'b1;
    repeat (3) tick();
    bus.arm = 1'b0;
    repeat (30) tick();
    pulse_arm(4, 0);
    wait_done(400);
    repeat (80) tick();
    check("held_arm_done_cnt", done_total - d0, 1);

    // half_period change mid-phase takes effect at the next boundary.
    wait_rise(40);
    repeat (3) tick();
    bus.half_period = 8'd6;
    for (int i = 0; i < 40; i++) begin
      if (bus.target_clk === 1'b0) break;
      tick();
    end
    wait_rise(40);
    tick();
    check("hp_change_old_high", hi_last, 10);
    check("hp_change_new_low", lo_last, 6);
    bus.half_period = 8'd10;
    wait_rise(40);
    wait_rise(40);

    // Reset during a glitch cuts it and restarts with a full low phase.
    align();
    pulse_arm(8, 0);
    for (int i = 0; i < 40; i++) begin
      if (bus.glitch_active === 1'b1) break;
      tick();
    end
    check("pre_rst_glitch", bus.glitch_active, 1);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_cut_outputs", {bus.target_clk, bus.glitch_active, bus.busy, bus.done}, 0);
    wait_rise(40);
    tick();
    check("rst_low_len", lo_last, 10);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bus.arm = ($urandom_range(29) == 0);
      bus.abort = ($urandom_range(79) == 0);
      bus.glitch_width = HALF_W'($urandom_range(15));
      bus.delay = CNT_W'($urandom_range(4));
      if ($urandom_range(99) == 0) bus.half_period = HALF_W'($urandom_range(12));
      rst = ($urandom_range(499) == 0);
      tick();
    end
    rst = 1'b0;
    bus.arm = 1'b0;
    bus.abort = 1'b0;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
